// File: rtl/iir_out_requant_if.sv
// Downstream sample handshake for the IIR output requantizer: head sample,
// its saturation flag, and a valid/ready pair.
interface iir_out_requant_if #(
  parameter int W = 16
);
  logic [W-1:0] q;
  logic         q_sat;
  logic         q_valid;
  logic         q_ready;

  modport master (output q, output q_sat, output q_valid, input q_ready);
  modport slave  (input q, input q_sat, input q_valid, output q_ready);
endinterface

// File: rtl/iir_out_requant.sv
// Output requantizer for the time-multiplexed IIR filter: captures one wide
// result per sample slot, rounds/saturates it to Q(WI).(WF), and queues it in a FIFO.
module iir_out_requant #(
  parameter int NUMBER   = 4,
  parameter int CAP_SLOT = 0,
  parameter int WI       = 5,
  parameter int WF       = 11,
  parameter int WIO      = 23,
  parameter int WFO      = 44,
  parameter int DEPTH    = 4
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       CE,
  input  logic                       we,
  input  logic [WIO+WFO-1:0]         din,
  iir_out_requant_if.master          sample_bus,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       sat_sticky,
  output logic                       drop_sticky,
  input  logic                       clr_sticky
);

  localparam int WIN = WIO + WFO;
  localparam int WO  = WI + WF;
  localparam int SH  = WFO - WF;
  localparam int WR  = WIN + 1 - SH;
  localparam int SW  = $clog2(NUMBER);
  localparam int AW  = $clog2(DEPTH);

  localparam logic [SW-1:0] SLOT_LAST = SW'(NUMBER - 1);
  localparam logic [SW-1:0] SLOT_CAP  = SW'(CAP_SLOT);
  localparam logic [WIN:0]  HALF      = (WIN + 1)'(1) << (SH - 1);

  typedef struct packed {
    logic          sat;
    logic [WO-1:0] sample;
  } entry_t;

  logic [SW-1:0]  slot;
  logic           stage_valid;
  logic [WIN-1:0] stage_din;
  logic [WIN:0]   rounded;
  logic [WR-1:0]  shifted;
  logic           ovf;
  entry_t         rq;
  entry_t         mem [DEPTH];
  entry_t         head;
  logic [AW:0]    wptr;
  logic [AW:0]    rptr;
  logic           full;
  logic           empty;
  logic           pop;
  logic           push_req;
  logic           push;
  logic           drop;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of process order.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      slot <= '0;
    end else if (!we) begin
      slot <= '0;
    end else if (CE) begin
      slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      stage_valid <= 1'b0;
      stage_din   <= '0;
    end else if (CE) begin
      stage_valid <= we && (slot == SLOT_CAP);
      if (we && (slot == SLOT_CAP)) stage_din <= din;
    end
  end

  // NOTE: every branch of this block assigns every output, so no latch is inferred.
  always_comb begin
    rounded = {stage_din[WIN-1], stage_din} + HALF;
    shifted = WR'(rounded >> SH);
    // Overflow when the bits above the output sign disagree with it.
    ovf     = !(&shifted[WR-1:WO-1]) && (|shifted[WR-1:WO-1]);
    rq.sat  = ovf;
    if (!ovf)                rq.sample = shifted[WO-1:0];
    else if (shifted[WR-1])  rq.sample = {1'b1, {(WO-1){1'b0}}};
    else                     rq.sample = {1'b0, {(WO-1){1'b1}}};
  end

  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty    = (wptr == rptr);
  assign pop      = !empty && sample_bus.q_ready;
  assign push_req = CE && stage_valid;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the head is masked with q_valid, so stale
  // entries are never visible and the array maps onto plain registers/RAM.
  always_ff @(posedge CLK) begin
    if (push) mem[wptr[AW-1:0]] <= rq;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      sat_sticky  <= 1'b0;
      drop_sticky <= 1'b0;
    end else begin
      sat_sticky  <= (sat_sticky && !clr_sticky) || (push && rq.sat);
      drop_sticky <= (drop_sticky && !clr_sticky) || drop;
    end
  end

  assign head               = mem[rptr[AW-1:0]];
  assign sample_bus.q_valid = !empty;
  assign sample_bus.q       = empty ? '0 : head.sample;
  assign sample_bus.q_sat   = !empty && head.sat;
  assign level              = wptr - rptr;

endmodule

// File: doc/iir_out_requant.md
# iir_out_requant

Output-side requantizer and buffer for the time-multiplexed IIR filter. It tracks the filter's section-slot sequence, captures the wide Q(WIO).(WFO) result once per input sample, and rounds and saturates it back to the Q(WI).(WF) sample format. Results are queued in a small FIFO and handed downstream over a valid/ready handshake. It is the consumer-end counterpart of the filter's sample-hold input, which holds each input sample for NUMBER cycles.

## Interface
Parameters:
- NUMBER, 4: cycles per sample (SOS sections time-multiplexed); ≥2
- CAP_SLOT, 0: slot index (0..NUMBER-1) at which din holds the finished result
- WI, 5: output integer bits (incl. sign)
- WF, 11: output fraction bits
- WIO, 23: input integer bits (incl. sign)
- WFO, 44: input fraction bits; WFO > WF, WIO ≥ WI
- DEPTH, 4: FIFO entries, power of two ≥2

Ports:
- CLK  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high
- CE  in  1  clock enable shared with filter
- we  in  1  filter run enable (same signal driving the filter)
- din  in  WIO+WFO  filter dout, two's complement Q(WIO).(WFO)
- q  out  WI+WF  requantized sample at FIFO head
- q_sat  out  1  head sample was saturated
- q_valid  out  1  FIFO non-empty
- q_ready  in  1  downstream accepts head
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- sat_sticky  out  1  any saturation since last clear
- drop_sticky  out  1  any sample lost to full FIFO since last clear
- clr_sticky  in  1  synchronous clear of both sticky flags

## Operation
- Slot counter: 0..NUMBER-1.
  - Advances on each CLK edge with CE&&we; wraps NUMBER-1 -> 0.
  - Holds when CE&&we is low.
  - Forced to 0 while we=0, keeping it aligned with the filter restart.
- Capture: on an edge with CE&&we and slot==CAP_SLOT, latch din into the round stage and set stage_valid; otherwise stage_valid=0.
- Requantization, combinational inside the round stage:
  - Sign-extend din by 1 bit.
  - Add 2^(WFO-WF-1), i.e. round half toward +inf.
  - Arithmetic shift right by WFO-WF.
- Saturation:
  - Result > 2^(WI+WF-1)-1 -> 0x7FFF-style max, sat=1.
  - Result < -2^(WI+WF-1) -> min, sat=1.
  - Otherwise sat=0.
- Push: stage_valid pushes {sat, sample} into the FIFO on the next edge.
  - Push and sat_sticky set occur only when the sample is accepted.
  - If FIFO is full and no pop occurs on that edge, the sample is dropped, drop_sticky=1, and FIFO contents are unchanged.
- Pop: occurs on an edge when q_valid&&q_ready.
- Full FIFO with simultaneous push+pop: both occur, level unchanged.
- Empty FIFO with push: q_valid cannot be high, so no pop.
- clr_sticky: clears both sticky flags.
  - clr_sticky wins over a same-edge set, except that an event on that same edge sets its flag again (set has priority).
- CE low: capture/stage/push paths freeze; FIFO pop still honours q_ready.

## Timing
- Reset values: slot=0, stage_valid=0, FIFO empty, q=0, q_sat=0, q_valid=0, level=0, sat_sticky=0, drop_sticky=0.
- Latency: capture edge E0 -> push at E1 -> q_valid high in the cycle after E1 (FIFO previously empty); q/q_sat valid whenever q_valid=1.
- Throughput: one sample per NUMBER enabled cycles; sustained with q_ready=1, level ≤1.
- q, q_sat driven from FIFO head storage; stable while q_valid&&!q_ready.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight stage sample and FIFO contents discarded.
- Pointer wrap at DEPTH uses an extra MSB for full/empty distinction; level = wptr-rptr.

## Test plan
- din=1<<44 (1.0), NUMBER=4, q_ready=1 -> q=0x0800, q_sat=0, q_valid pulses once per 4 cycles, 2 cycles after each CAP_SLOT edge.
- Rounding:
  - din=1<<32 (2^-12) -> q=0x0001.
  - din=-(1<<32) -> q=0x0000.
  - din=(1<<33)-1 -> q=0x0001.
- Saturation:
  - din=20.0 (20<<44) -> q=0x7FFF, q_sat=1, sat_sticky=1.
  - din=-16.0 -> q=0x8000, q_sat=0.
  - din=-17.0 -> q=0x8000, q_sat=1.
- Backpressure: q_ready=0 for 6 samples, DEPTH=4.
  - level climbs to 4, 5th and 6th samples dropped, drop_sticky=1.
  - Releasing q_ready drains the first 4 samples in order, one per cycle.
  - clr_sticky clears both sticky flags.
- Full with same-edge push+pop: level stays 4, no drop, order preserved.
- Reset after 2 queued samples and a pending stage: next cycle q_valid=0, level=0, slot=0.
  - With we toggled 0->1, the first capture occurs at the CAP_SLOT edge after restart.
